nibble_serial_sub: RTL
======================

# nibble_serial_sub

Multi-cycle subtractor that computes `diff = a - b - bin` one 4-bit nibble per clock, LSB nibble first, rippling the borrow between cycles. It is the subtract counterpart to the 4-bit adder slice in the integer ALU. It is used where a full-width ripple subtract would not close timing. It registers signed/unsigned status flags for the ALU flag logic and uses a start/busy/done handshake.

## Interface
- `NIBBLES`, default 4: number of 4-bit slices. Operand width `W = 4*NIBBLES`. Legal range 1–16.
- `clk` in, 1: single clock; all logic on rising edge.
- `rst_n` in, 1: reset, synchronous, active-low.
- `start` in, 1: request; sampled only in IDLE.
- `a` in, W: minuend; latched when start is accepted.
- `b` in, W: subtrahend; latched when start is accepted.
- `bin` in, 1: borrow-in; latched when start is accepted.
- `busy` out, 1: high while nibbles are being processed.
- `done` out, 1: one-cycle pulse when results are valid.
- `diff` out, W: result `(a - b - bin) mod 2^W`.
- `bout` out, 1: final borrow-out; 1 iff `a < b + bin` (unsigned).
- `zero` out, 1: `diff == 0`.
- `neg` out, 1: `diff[W-1]`.
- `ovf` out, 1: signed overflow, `(a[W-1]^b[W-1]) & (diff[W-1]^a[W-1])`.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE**
  - On an edge with `start=1`: latch `a`, `b`, `bin` into internal registers, clear the nibble index, move to RUN.
  - With `start=0`: stay in IDLE.
- **RUN**
  - Each edge processes nibble i: `{borrow', d_i} = a_i - b_i - borrow`. The borrow starts at the latched `bin`. Result nibble i goes into an internal accumulator; the index increments.
  - After the edge that processes nibble NIBBLES-1, move to DONE. On that same edge, load `diff`, `bout`, `zero`, `neg` and `ovf` from the completed accumulator and the final borrow.
- **DONE**
  - Lasts exactly one cycle, then returns to IDLE unconditionally.
- Outputs are driven by registers only:
  - `busy = (state==RUN)`.
  - `done = (state==DONE)`.
- `diff`, `bout` and the flags change only on the edge that enters DONE. They hold their value through IDLE and through the next RUN until the next result loads; no partial results are visible.
- `start` is ignored in RUN and DONE; no queuing. Operand inputs may change freely after acceptance.
- `ovf` uses the latched `a` and `b` MSBs. The formula is valid for any `bin`.
- `zero` and `ovf` are evaluated on the full W-bit result, never per nibble.

## Timing
- Reset values (`rst_n=0` at an edge):
  - state = IDLE.
  - `busy`, `done`, `diff`, `bout`, `zero`, `neg`, `ovf` all 0.
  - Internal operand registers, accumulator and index cleared.
- Reset has priority over every other action. Reset during RUN aborts the operation: no `done` pulse, result registers cleared. Reset in DONE kills the pulse on the next cycle.
- Start accepted at edge E:
  - `busy` is high from E through E+NIBBLES, i.e. NIBBLES cycles.
  - `done` is high for the one cycle after edge E+NIBBLES.
  - Results are valid in that same cycle.
- Latency is NIBBLES+1 edges from acceptance to results valid and `done` high.
- Back-to-back operation: the earliest next acceptance is the edge following the DONE cycle. Throughput is one operation per NIBBLES+2 cycles.
- `start` held high continuously: a new operation is accepted at every IDLE.

## Test plan
All scenarios use NIBBLES=4 (W=16).
1. Latency and basic function:
   - Stimulus: `a=0x0003`, `b=0x0001`, `bin=0`, start at edge E.
   - Required: `busy` high for 4 cycles. `done` high exactly one cycle after E+4 with `diff=0x0002`, `bout=0`, `zero=0`, `neg=0`, `ovf=0`.
2. Unsigned wrap:
   - Stimulus: `a=0x0000`, `b=0x0001`, `bin=0`.
   - Required: `diff=0xFFFF`, `bout=1`, `neg=1`, `ovf=0`.
   - Then `a=0x1000`, `b=0x0001`.
   - Required: `diff=0x0FFF`, `bout=0`, borrow rippling across three nibbles.
3. Signed overflow:
   - Stimulus: `a=0x8000`, `b=0x0001`, `bin=0`.
   - Required: `diff=0x7FFF`, `ovf=1`, `neg=0`, `bout=0`.
   - Then `a=0x7FFF`, `b=0xFFFF`.
   - Required: `diff=0x8000`, `ovf=1`, `bout=1`.
4. Borrow-in:
   - Stimulus: `a=0x1234`, `b=0x1233`, `bin=1`.
   - Required: `diff=0x0000`, `zero=1`, `bout=0`.
   - Then `a=0x0000`, `b=0x0000`, `bin=1`.
   - Required: `diff=0xFFFF`, `bout=1`.
5. Handshake:
   - Stimulus: pulse `start` with new operands during RUN and during DONE.
   - Required: both ignored; the first result is unchanged.
   - Stimulus: `start` held high continuously.
   - Required: `done` pulses every 6 cycles.
6. Reset:
   - Stimulus: `rst_n=0` for one edge two cycles into RUN.
   - Required: next cycle all outputs are 0, no `done` pulse, state IDLE.
   - Then start a fresh operation.
   - Required: it completes normally.

Source files
------------

// File: rtl/nibble_serial_sub.sv
// nibble_serial_sub: computes diff = a - b - bin one 4-bit nibble per clock,
// LSB nibble first, rippling the borrow between cycles. Result and status
// flags load together when the last nibble completes; start/busy/done
// handshake around the operation.
module nibble_serial_sub #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 bin,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] diff,
    output logic                 bout,
    output logic                 zero,
    output logic                 neg,
    output logic                 ovf
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_n;

    logic [W-1:0]  a_q, b_q;   // operands latched at acceptance
    logic [W-1:0]  acc;        // partial result, filled nibble by nibble
    logic [W-1:0]  acc_n;      // accumulator with the current nibble merged
    logic [IW-1:0] idx;        // nibble being processed
    logic          borrow;     // borrow carried into the current nibble
    logic [3:0]    nib_a, nib_b, nib_d;
    logic          borrow_n;
    logic          last;

    assign last = (idx == LAST_IDX);

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of block ordering.
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Next-state logic; start only matters in IDLE.
    always_comb begin
        // NOTE: default assigned first so no path leaves state_n unassigned,
        // which would otherwise infer a latch.
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = RUN;
            RUN:     if (last)  state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // One nibble of subtraction; the 5th bit of the widened difference is
    // the borrow out of this nibble.
    always_comb begin
        nib_a = a_q[4*idx +: 4];
        nib_b = b_q[4*idx +: 4];
        {borrow_n, nib_d} = {1'b0, nib_a} - {1'b0, nib_b} - {4'b0000, borrow};
        acc_n = acc;
        acc_n[4*idx +: 4] = nib_d;
    end

    // Operand capture, nibble stepping and result/flag load on the last nibble.
    always_ff @(posedge clk) begin
        // NOTE: every register, including the operand/accumulator storage,
        // is cleared so an aborted operation leaves no stale data behind.
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            acc    <= '0;
            idx    <= '0;
            borrow <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
            zero   <= 1'b0;
            neg    <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q    <= a;
                        b_q    <= b;
                        borrow <= bin;
                        idx    <= '0;
                        acc    <= '0;
                    end
                end
                RUN: begin
                    acc    <= acc_n;
                    borrow <= borrow_n;
                    idx    <= idx + 1'b1;
                    if (last) begin
                        diff <= acc_n;
                        bout <= borrow_n;
                        zero <= (acc_n == '0);
                        neg  <= acc_n[W-1];
                        ovf  <= (a_q[W-1] ^ b_q[W-1]) & (acc_n[W-1] ^ a_q[W-1]);
                    end
                end
                default: ;
            endcase
        end
    end

    // Handshake outputs decode straight from the state register.
    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule
